// File: rtl/spi_master.sv
// rtl/spi_master.sv - Mode-0 SPI initiator with start/busy/done host handshake
// One full-duplex MSB-first word per transfer; every SPI pin is driven from a flop.
module spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_clk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);
    localparam int HW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

    state_t                state;
    logic [HW-1:0]         half_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  half_end;

    assign half_end = (half_cnt == HALF_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            spi_clk  <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    half_cnt <= '0;
                    if (start) begin
                        // tx_shift holds only the bits still to be presented after the MSB
                        tx_shift <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                        mosi     <= tx_data[DATA_WIDTH-1];
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        cs_n     <= 1'b0;
                        state    <= LEAD;
                    end
                end
                LEAD, LOW: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        spi_clk  <= 1'b1;
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
                        bit_cnt  <= bit_cnt + 1'b1;
                        state    <= HIGH;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        spi_clk  <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= TRAIL;
                        end else begin
                            mosi     <= tx_shift[DATA_WIDTH-1];
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                            state    <= LOW;
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        cs_n     <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rx_data  <= rx_shift;
                        mosi     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
